// File: rtl/control_unit_pkg.sv
// control_unit_pkg: instruction-type, PC-next and rd-source encodings, FSM states and control word
package control_unit_pkg;
  localparam int INST_TYPE_WIDTH = 3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_NOP     = 3'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_IMM     = 3'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_IMM = 3'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_INT_REG = 3'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_BRANCH  = 3'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_STORE   = 3'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_TYPE_JAL     = 3'd6;
  localparam int PC_NEXT_SEL_WIDTH = 1;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_INCR    = 1'b0;
  localparam logic [PC_NEXT_SEL_WIDTH-1:0] PC_NEXT_ADD_IMM = 1'b1;
  localparam int RD_DIN_SEL_WIDTH = 2;
  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_ALU = 2'd0;
  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_IMM = 2'd1;
  localparam logic [RD_DIN_SEL_WIDTH-1:0] RD_DIN_PC4 = 2'd2;
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PC
  } state_t;
  typedef struct packed {
    logic                         inst_fetch;
    logic                         load_pc;
    logic [PC_NEXT_SEL_WIDTH-1:0] pc_next_sel;
    logic                         rs1_en;
    logic                         rs2_en;
    logic                         rd_en;
    logic [RD_DIN_SEL_WIDTH-1:0]  rd_din_sel;
    logic                         alu_en;
    logic                         alu_din2_sel;
    logic                         store_req;
  } ctrl_t;
  function automatic logic uses_alu(input logic [INST_TYPE_WIDTH-1:0] t);
    return t == INST_TYPE_INT_IMM || t == INST_TYPE_INT_REG || t == INST_TYPE_BRANCH || t == INST_TYPE_STORE;
  endfunction
  function automatic logic uses_rs2(input logic [INST_TYPE_WIDTH-1:0] t);
    return t == INST_TYPE_INT_REG || t == INST_TYPE_BRANCH || t == INST_TYPE_STORE;
  endfunction
  function automatic logic writes_rd(input logic [INST_TYPE_WIDTH-1:0] t);
    return t == INST_TYPE_IMM || t == INST_TYPE_JAL || t == INST_TYPE_INT_IMM || t == INST_TYPE_INT_REG;
  endfunction
endpackage

// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer of the copperv core, one FSM state per instruction phase
//   in:  clk, rst (sync, active high), inst_type, inst_valid, alu_comp, store_done
//   out: inst_fetch, load_pc, pc_next_sel, rs1_en, rs2_en, rd_en, rd_din_sel, alu_en,
//        alu_din2_sel, store_req (all registered, all 0 in reset)
module control_unit
  import control_unit_pkg::*;
#(
  parameter int RESET_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INST_TYPE_WIDTH-1:0]   inst_type,
  input  logic                         inst_valid,
  input  logic                         alu_comp,
  input  logic                         store_done,
  output logic                         inst_fetch,
  output logic                         load_pc,
  output logic [PC_NEXT_SEL_WIDTH-1:0] pc_next_sel,
  output logic                         rs1_en,
  output logic                         rs2_en,
  output logic                         rd_en,
  output logic [RD_DIN_SEL_WIDTH-1:0]  rd_din_sel,
  output logic                         alu_en,
  output logic                         alu_din2_sel,
  output logic                         store_req
);
  localparam int CW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
  state_t                       state, next_state;
  logic [CW-1:0]                cnt;
  logic [INST_TYPE_WIDTH-1:0]   type_q, type_d;
  logic                         taken_q, taken_d;
  ctrl_t                        ctrl_q, ctrl_d;
  logic                         done;
  assign done = cnt == CW'(RESET_CYCLES - 1);
  // Outputs are registered from the upcoming state, so each lines up with the state it belongs to.
  // The decoder output is live through FETCH (once inst_valid) and DECODE; after that type_q rules.
  always_comb begin
    type_d = (state == S_FETCH || state == S_DECODE) ? inst_type : type_q;
    taken_d = state == S_EXEC ? alu_comp && type_q == INST_TYPE_BRANCH : taken_q;
    next_state = S_RESET;
    case (state)
      S_RESET:  next_state = done ? S_FETCH : S_RESET;
      // inst_fetch is high only in the first FETCH cycle, which is exactly when inst_valid is ignored
      S_FETCH:  next_state = (!ctrl_q.inst_fetch && inst_valid) ? S_DECODE : S_FETCH;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   next_state = writes_rd(type_q) ? S_WB : type_q == INST_TYPE_STORE ? S_MEM : S_PC;
      S_MEM:    next_state = store_done ? S_PC : S_MEM;
      S_WB:     next_state = S_PC;
      S_PC:     next_state = S_FETCH;
      default:  next_state = S_RESET;
    endcase
    ctrl_d = '0;
    ctrl_d.inst_fetch = next_state == S_FETCH && state != S_FETCH;
    ctrl_d.rs1_en = next_state == S_DECODE && uses_alu(type_d);
    ctrl_d.rs2_en = next_state == S_DECODE && uses_rs2(type_d);
    ctrl_d.alu_en = next_state == S_EXEC && uses_alu(type_d);
    ctrl_d.alu_din2_sel = next_state == S_EXEC && (type_d == INST_TYPE_INT_IMM || type_d == INST_TYPE_STORE);
    ctrl_d.store_req = next_state == S_MEM;
    ctrl_d.rd_en = next_state == S_WB;
    ctrl_d.rd_din_sel = next_state != S_WB ? RD_DIN_ALU :
                        type_d == INST_TYPE_IMM ? RD_DIN_IMM :
                        type_d == INST_TYPE_JAL ? RD_DIN_PC4 : RD_DIN_ALU;
    ctrl_d.load_pc = next_state == S_PC;
    ctrl_d.pc_next_sel = (next_state == S_PC && (type_d == INST_TYPE_JAL || taken_d)) ? PC_NEXT_ADD_IMM : PC_NEXT_INCR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      cnt     <= '0;
      type_q  <= INST_TYPE_NOP;
      taken_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state   <= next_state;
      cnt     <= (state == S_RESET && !done) ? cnt + 1'b1 : cnt;
      type_q  <= state == S_DECODE ? inst_type : type_q;
      taken_q <= taken_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign inst_fetch   = ctrl_q.inst_fetch;
  assign load_pc      = ctrl_q.load_pc;
  assign pc_next_sel  = ctrl_q.pc_next_sel;
  assign rs1_en       = ctrl_q.rs1_en;
  assign rs2_en       = ctrl_q.rs2_en;
  assign rd_en        = ctrl_q.rd_en;
  assign rd_din_sel   = ctrl_q.rd_din_sel;
  assign alu_en       = ctrl_q.alu_en;
  assign alu_din2_sel = ctrl_q.alu_din2_sel;
  assign store_req    = ctrl_q.store_req;
endmodule
